// File: rtl/sbus_pkg.sv
// Shared SBUS RAM-disk definitions: bus widths,
// FSM state encoding and default poison read value.
package sbus_pkg;

  localparam int SBUS_ADDR_W = 40;
  localparam int SBUS_DATA_W = 16;

  localparam logic [SBUS_DATA_W-1:0] SBUS_POISON =
    16'hDEAD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_READ_WAIT,
    S_WRITE,
    S_DONE
  } sbus_state_t;

endpackage

// File: rtl/sbus_ram_disk_mem.sv
// Single-port synchronous RAM, 2**DEPTH_LOG2 x 16, 1-cycle read.
// Ports: sys_clk, we, re, addr, wdata, rdata (registered).
module sbus_ram_disk_mem
  import sbus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                   sys_clk,
  input  logic                   we,
  input  logic                   re,
  input  logic [DEPTH_LOG2-1:0]  addr,
  input  logic [SBUS_DATA_W-1:0] wdata,
  output logic [SBUS_DATA_W-1:0] rdata
);

  logic [SBUS_DATA_W-1:0] ram [2**DEPTH_LOG2];

  // No reset: contents survive usbreset, maps to block RAM.
  always_ff @(posedge sys_clk) begin
    if (we) ram[addr] <= wdata;
    if (re) rdata <= ram[addr];
  end

endmodule

// File: rtl/sbus_ram_disk.sv
// SBUS RAM disk: CDC'd start_op handshake, FSM, op counter.
// Ports: sys_clk, usbreset (async, active-high), sbus_start_op,
// sbus_rw, sbus_address, sbus_data_in, sbus_data_out,
// sbus_data_oe, sbus_ready, op_count, err_flag.
// Macro SBUS_RAM_DISK_BOUNDS_CHECK_EN enables the bounds check.
module sbus_ram_disk
  import sbus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter logic [SBUS_DATA_W-1:0] POISON = SBUS_POISON
) (
  input  logic                   sys_clk,
  input  logic                   usbreset,
  input  logic                   sbus_start_op,
  input  logic                   sbus_rw,
  input  logic [SBUS_ADDR_W-1:0] sbus_address,
  input  logic [SBUS_DATA_W-1:0] sbus_data_in,
  output logic [SBUS_DATA_W-1:0] sbus_data_out,
  output logic                   sbus_data_oe,
  output logic                   sbus_ready,
  output logic [15:0]            op_count,
  output logic                   err_flag
);

  sbus_state_t state;
  sbus_state_t state_n;

  logic sync_a;
  logic sync_b;
  logic sync_c;
  logic rise;
  logic take;
  logic done_entry;

  logic                   rw_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [SBUS_DATA_W-1:0] wdata_q;
  logic [SBUS_DATA_W-1:0] mem_rdata;
  logic                   mem_we;
  logic                   mem_re;
  logic                   oor;

  assign rise = sync_b & ~sync_c;
  assign take = (state == S_IDLE) & rise;
  assign done_entry = (state == S_READ_WAIT) |
                      (state == S_WRITE);

  // State register
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state. A start pulse too short to still be high in
  // CAPTURE is treated as a glitch and dropped.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (rise) state_n = S_CAPTURE;
      S_CAPTURE:
        if (!sync_b)   state_n = S_IDLE;
        else if (rw_q) state_n = S_READ_WAIT;
        else           state_n = S_WRITE;
      S_READ_WAIT: state_n = S_DONE;
      S_WRITE:     state_n = S_DONE;
      S_DONE:
        if (!sync_b) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    sbus_ready   = 1'b0;
    sbus_data_oe = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    unique case (state)
      S_IDLE:    sbus_ready = 1'b1;
      S_CAPTURE: mem_re = rw_q;
      S_WRITE:   mem_we = ~oor;
      S_DONE: begin
        sbus_ready   = 1'b1;
        sbus_data_oe = rw_q;
      end
      default: ;
    endcase
  end

  // Synchronizer, request capture, read data, counter
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      sync_a        <= 1'b0;
      sync_b        <= 1'b0;
      sync_c        <= 1'b0;
      rw_q          <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      sbus_data_out <= '0;
      op_count      <= '0;
    end else begin
      sync_a <= sbus_start_op;
      sync_b <= sync_a;
      sync_c <= sync_b;
      if (take) begin
        rw_q    <= sbus_rw;
        idx_q   <= sbus_address[DEPTH_LOG2-1:0];
        wdata_q <= sbus_data_in;
      end
      if (done_entry) begin
        op_count <= op_count + 16'd1;
        if (rw_q)
          sbus_data_out <= oor ? POISON : mem_rdata;
      end
    end
  end

`ifdef SBUS_RAM_DISK_BOUNDS_CHECK_EN
  // Range is decided once at capture; the flag is sticky.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      oor      <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      if (take)
        oor <= |sbus_address[SBUS_ADDR_W-1:DEPTH_LOG2];
      if (done_entry && oor)
        err_flag <= 1'b1;
    end
  end
`else
  logic unused_addr;
  assign unused_addr =
    ^sbus_address[SBUS_ADDR_W-1:DEPTH_LOG2];
  assign oor      = 1'b0;
  assign err_flag = 1'b0;
`endif

  sbus_ram_disk_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .sys_clk(sys_clk),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (idx_q),
    .wdata  (wdata_q),
    .rdata  (mem_rdata)
  );

endmodule
